// File: rtl/simd_decode_stage_if.sv
// Instruction-push and decoded-result bus of the SIMD decode stage.
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid && ready are both 1; the sender keeps its payload stable
// while valid is high and ready is low.
interface simd_decode_stage_if #(
    parameter int ADDR_W = 9
);
    logic              in_valid;
    logic [31:0]       in_instr;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_type;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [4:0]        out_rd;
    logic [5:0]        out_shamt;
    logic [11:0]       out_imm;
    logic [ADDR_W-1:0] out_addr;
    logic              out_illegal;

    // Instruction source / result sink side.
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_type, out_rs1, out_rs2, out_rd,
               out_shamt, out_imm, out_addr, out_illegal
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_type, out_rs1, out_rs2, out_rd,
               out_shamt, out_imm, out_addr, out_illegal
    );
endinterface

// File: rtl/simd_decode_stage.sv
// SIMD decode stage: instruction FIFO feeding a registered decoder with a
// RUN/HALT control FSM. A RET reaching the output register halts popping
// until resume; flush empties everything synchronously.
module simd_decode_stage #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    simd_decode_stage_if.slave         bus,
    input  logic                       flush,
    input  logic                       resume,
    output logic                       halted,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       state_dbg
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [3:0] T_NOP  = 4'b0000;
    localparam logic [3:0] T_SUB  = 4'b0001;
    localparam logic [3:0] T_MUL  = 4'b0010;
    localparam logic [3:0] T_ADD  = 4'b0011;
    localparam logic [3:0] T_FADD = 4'b0100;
    localparam logic [3:0] T_FSUB = 4'b0101;
    localparam logic [3:0] T_LOAD = 4'b0110;
    localparam logic [3:0] T_RET  = 4'b0111;
    localparam logic [3:0] T_ADDI = 4'b1000;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [31:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [31:0]        head;
    logic               push;
    logic               load;
    logic [3:0]         dec_type;
    logic [11:0]        dec_imm;
    logic               dec_illegal;

    assign head        = mem[rd_ptr];
    assign bus.in_ready = (level < LVL_W'(DEPTH)) && !flush;
    assign push        = bus.in_valid && bus.in_ready;
    // Loading the output register is the only way the FIFO head is popped.
    assign load        = (level != '0) && (state_q == RUN)
                         && (!bus.out_valid || bus.out_ready) && !flush;
    assign halted      = (state_q == HALT);
    assign state_dbg   = state_q;

    // Storage array: written on push only, contents are don't-care when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_instr;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({push, load})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Opcode classification of the FIFO head word.
    always_comb begin
        dec_type    = T_NOP;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        if (head[31:22] == 10'b1001000100) begin
            dec_type = T_ADDI;
            dec_imm  = head[21:10];
        end else begin
            case (head[31:21])
                11'b00000000000: dec_type = T_NOP;
                11'b11001011000: dec_type = T_SUB;
                11'b10011011000: dec_type = T_MUL;
                11'b10001011000: dec_type = T_ADD;
                11'b10101010101: dec_type = T_LOAD;
                11'b11111111111: dec_type = T_RET;
                11'b00011110011: begin
                    if (head[15:10] == 6'b001010) begin
                        dec_type = T_FADD;
                    end else if (head[15:10] == 6'b001110) begin
                        dec_type = T_FSUB;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    // Output register: loads on pop, holds while stalled, empties when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.out_type    <= '0;
            bus.out_rs1     <= '0;
            bus.out_rs2     <= '0;
            bus.out_rd      <= '0;
            bus.out_shamt   <= '0;
            bus.out_imm     <= '0;
            bus.out_addr    <= '0;
            bus.out_illegal <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (load) begin
            bus.out_valid   <= 1'b1;
            bus.out_type    <= dec_type;
            bus.out_rs1     <= head[9:5];
            bus.out_rs2     <= head[20:16];
            bus.out_rd      <= head[4:0];
            bus.out_shamt   <= head[15:10];
            bus.out_imm     <= dec_imm;
            bus.out_addr    <= head[12 +: ADDR_W];
            bus.out_illegal <= dec_illegal;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: halt when a RET enters the output register, run on resume.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (load && dec_type == T_RET) state_d = HALT;
                HALT:    if (resume) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end
endmodule

// File: doc/simd_decode_stage.md
SIMD_DECODE_STAGE -- requirements
Module: simd_decode_stage

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 4, as the instruction FIFO depth (power of two, >=2).
REQ-002 The block SHALL expose parameter ADDR_W, default 9, as the load-address width (<=12).
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports in_valid  input  1, in_instr  input  32, in_ready  output  1, forming the instruction-push handshake.
REQ-006 The block SHALL have ports out_valid  output  1, out_ready  input  1, forming the decoded-result handshake.
REQ-007 The block SHALL have registered outputs out_type  output  4, out_rs1  output  5, out_rs2  output  5, out_rd  output  5, out_shamt  output  6, out_imm  output  12, out_addr  output  ADDR_W, out_illegal  output  1.
REQ-008 The block SHALL have ports flush  input  1 (sync clear), resume  input  1 (leave HALT), halted  output  1, level  output  $clog2(DEPTH)+1 (FIFO occupancy).

Function
REQ-009 Push occurs when in_valid && in_ready; in_ready = (level < DEPTH) && !flush.
REQ-010 Decode SHALL apply to the FIFO head word; the output register loads when the FIFO is non-empty, state is RUN, and (!out_valid || out_ready); load pops the head.
REQ-011 Latency SHALL be 2 cycles: an instruction pushed at edge N appears with out_valid=1 after edge N+1 at the earliest (empty FIFO, output free).
REQ-012 Type map on bits [31:21]: 00000000000 -> 0000 NOP; 11001011000 -> 0001 SUB; 10011011000 -> 0010 MUL; 10001011000 -> 0011 ADD; 00011110011 with [15:10]=001010 -> 0100 FADD; 00011110011 with [15:10]=001110 -> 0101 FSUB; 10101010101 -> 0110 LOAD; 11111111111 -> 0111 RET.
REQ-013 Bits [31:22]=1001000100 SHALL decode as 1000 ADDI with out_imm = instr[21:10]; out_imm = 0 for every other type.
REQ-014 Unmatched opcodes (including 00011110011 with other [15:10]) SHALL decode as 0000 with out_illegal=1; out_illegal=0 otherwise.
REQ-015 Fields SHALL be out_rd=[4:0], out_rs1=[9:5], out_rs2=[20:16], out_shamt=[15:10], out_addr=[12+ADDR_W-1:12], for all types.
REQ-016 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-017 FSM states RUN, HALT: RUN->HALT when a RET is loaded into the output register; HALT->RUN on resume; in HALT no pop occurs but pushes continue until full; resume in RUN is ignored; halted=1 iff HALT.
REQ-018 Pop and push in the same cycle SHALL leave level unchanged; pointers wrap modulo DEPTH.
REQ-019 flush SHALL, next edge, clear FIFO (level=0), out_valid=0, state=RUN; flush overrides push, pop, resume.

Reset
REQ-020 rst_n low SHALL immediately force level=0, pointers=0, out_valid=0, state RUN, halted=0, and all out_* fields to 0.
REQ-021 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions; the first valid after release comes from a new push.

Verification
REQ-022 Push 0x8B020020 with out_ready=1 -> two cycles later out_valid=1, type=0011, rd=0, rs1=1, rs2=2, illegal=0.
REQ-023 Push 0x1E622820 -> type=0100 FADD; push 0x1E623C20 -> type=0000, illegal=1.
REQ-024 Push 0x910FFC41 (ADDI) -> type=1000, imm=0x3FF, rd=1, rs1=2.
REQ-025 Hold out_ready=0, push DEPTH+1 words -> level=DEPTH, in_ready=0, first output stable; release out_ready -> all DEPTH+1 words emerge in order, none lost.
REQ-026 Push RET 0xFFE00000 then ADD -> RET emitted, halted=1, ADD held (level=1); pulse resume -> ADD emitted next.
REQ-027 Fill FIFO, assert flush with in_valid=1 -> next cycle level=0, out_valid=0, nothing pushed; drop rst_n mid-stream -> outputs zero asynchronously.
